// File: rtl/regbank_access_arbiter_if.sv
// Request/response handshakes for all requesters plus the register bank access port.
// The arbiter uses the slave modport; requesters and the bank sit on the master side.
interface regbank_access_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 8
) ();
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        req_wr_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*8-1:0]      req_wdata_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ-1:0]        rsp_ready_i;
    logic [7:0]                rsp_rdata_o;
    logic                      acc_en_o;
    logic                      wr_en_o;
    logic [ADDR_W-1:0]         addr_o;
    logic [7:0]                wdata_o;
    logic [7:0]                rdata_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i, rsp_ready_i, rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, acc_en_o, wr_en_o, addr_o, wdata_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_addr_i, req_wdata_i, rsp_ready_i, rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, acc_en_o, wr_en_o, addr_o, wdata_o
    );
endinterface

// File: rtl/regbank_access_arbiter.sv
// Round-robin arbiter sharing the filter register bank port between NUM_REQ requesters.
// One single-cycle bank access per transaction, then a registered response to the owner.
module regbank_access_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    regbank_access_arbiter_if.slave  bus,
    output logic                     busy_o
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic                acc_en_q, acc_en_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  req_ready;
    logic [NUM_REQ-1:0]  rsp_valid;
    logic                win_valid;
    logic [IdxW-1:0]     win_idx;
    logic [ADDR_W-1:0]   req_addr [NUM_REQ];
    logic [7:0]          req_wdata [NUM_REQ];

    always_comb begin
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            req_addr[k]  = bus.req_addr_i[k*ADDR_W +: ADDR_W];
            req_wdata[k] = bus.req_wdata_i[k*8 +: 8];
        end
    end

    // First valid requester scanning from ptr_q upwards, wrapping at NUM_REQ.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand     = (int'(ptr_q) + i) % int'(NUM_REQ);
            cand_idx = IdxW'(cand);
            if (!win_valid && bus.req_valid_i[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        acc_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        rdata_d   = rdata_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    req_ready[win_idx] = 1'b1;
                    owner_d  = win_idx;
                    acc_en_d = 1'b1;
                    wr_en_d  = bus.req_wr_i[win_idx];
                    addr_d   = req_addr[win_idx];
                    wdata_d  = req_wdata[win_idx];
                    if (win_idx == IdxW'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + 1'b1;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                rdata_d = wr_en_q ? 8'h00 : bus.rdata_i;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready_i[owner_q]) begin
                    rdata_d = 8'h00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            acc_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            acc_en_q <= acc_en_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.acc_en_o    = acc_en_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.addr_o      = addr_q;
    assign bus.wdata_o     = wdata_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Directed bench for regbank_access_arbiter: small register bank model, per-cycle protocol
// monitor and a response scoreboard filled at grant time from a shadow copy of the bank.
module tb_regbank_access_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = $clog2(NR);
    localparam logic [7:0]  STATUS_ADDR = 8'h0F;

    typedef logic [IW-1:0] rid_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    regbank_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

    regbank_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Register bank: 16 bytes, address 0x0F is a read-clear status register.
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] status   = 8'h00;
    logic [7:0] inj_v    = 8'h00;

    always_comb begin
        bus.rdata_i = 8'h00;
        if (bus.acc_en_o && !bus.wr_en_o) begin
            if (bus.addr_o == STATUS_ADDR) bus.rdata_i = status;
            else if (bus.addr_o < 8'd16) bus.rdata_i = mem[bus.addr_o[3:0]];
        end
    end

    always @(posedge clk) begin
        if (bus.acc_en_o && bus.wr_en_o && bus.addr_o < 8'd16 && bus.addr_o != STATUS_ADDR)
            mem[bus.addr_o[3:0]] <= bus.wdata_o;
        if (bus.acc_en_o && !bus.wr_en_o && bus.addr_o == STATUS_ADDR) status <= inj_v;
        else status <= status | inj_v;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference state for the monitor
    logic [7:0] sh_mem [16] = '{default: 8'h00};
    logic [7:0] sh_status   = 8'h00;
    logic [7:0] exp_q [$];
    int         grant_log [$];
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_owner = 0;
    logic       m_wr    = 1'b0;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input rid_t k, input logic wr, input logic [7:0] a,
                           input logic [7:0] d);
        bus.req_wr_i[k]             = wr;
        bus.req_addr_i[k*AW +: AW]  = a;
        bus.req_wdata_i[k*8 +: 8]   = d;
        bus.req_valid_i[k]          = 1'b1;
    endtask

    // Present a request, hold it until granted, then drop it after the accepting edge.
    task automatic issue(input rid_t k, input logic wr, input logic [7:0] a,
                         input logic [7:0] d);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        set_req(k, wr, a, d);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready_o[k]) begin
                got = 1'b1;
                break;
            end
        end
        chk("grant_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            if (m_phase == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_wait", 32'(done), 32'd1);
    endtask

    task automatic wait_phase(input int ph);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (m_phase == ph) begin
                done = 1'b1;
                break;
            end
        end
        chk("phase_wait", 32'(done), 32'd1);
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_wr_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = '1;

        fork
            forever begin
                int          w;
                logic [7:0]  a, d, ed;
                logic        wr;
                logic [NR-1:0] exp_ready;
                @(negedge clk);
                if (!rstn) begin
                    m_phase = 0;
                    m_ptr   = 0;
                    exp_q.delete();
                    chk("rst_acc_en", 32'(bus.acc_en_o), 32'd0);
                    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
                    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                end else begin
                    sh_status = sh_status | inj_v;
                    chk("ready_onehot", 32'($onehot0(bus.req_ready_o)), 32'd1);
                    chk("rspv_onehot", 32'($onehot0(bus.rsp_valid_o)), 32'd1);
                    case (m_phase)
                        0: begin
                            w = -1;
                            for (int i = 0; i < int'(NR); i++) begin
                                if (w < 0 && bus.req_valid_i[rid_t'((m_ptr + i) % int'(NR))])
                                    w = (m_ptr + i) % int'(NR);
                            end
                            exp_ready = (w >= 0) ? (NR'(1) << w) : '0;
                            chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
                            chk("idle_acc_en", 32'(bus.acc_en_o), 32'd0);
                            chk("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
                            chk("idle_busy", 32'(busy), 32'd0);
                            chk("idle_bus", {15'd0, bus.wr_en_o, bus.addr_o, bus.wdata_o}, 32'd0);
                            if (w >= 0) begin
                                wr = bus.req_wr_i[rid_t'(w)];
                                a  = bus.req_addr_i[w*AW +: AW];
                                d  = bus.req_wdata_i[w*8 +: 8];
                                ed = 8'h00;
                                if (wr) begin
                                    if (a < 8'd16 && a != STATUS_ADDR) sh_mem[a[3:0]] = d;
                                end else if (a == STATUS_ADDR) begin
                                    ed = sh_status;
                                    sh_status = 8'h00;
                                end else if (a < 8'd16) begin
                                    ed = sh_mem[a[3:0]];
                                end
                                exp_q.push_back(ed);
                                grant_log.push_back(w);
                                m_owner = w;
                                m_wr    = wr;
                                m_addr  = a;
                                m_wdata = d;
                                m_ptr   = (w + 1) % int'(NR);
                                m_phase = 1;
                            end
                        end
                        1: begin
                            chk("acc_en", 32'(bus.acc_en_o), 32'd1);
                            chk("wr_en", 32'(bus.wr_en_o), 32'(m_wr));
                            chk("addr", 32'(bus.addr_o), 32'(m_addr));
                            chk("wdata", 32'(bus.wdata_o), 32'(m_wdata));
                            chk("acc_req_ready", 32'(bus.req_ready_o), 32'd0);
                            chk("acc_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
                            chk("acc_busy", 32'(busy), 32'd1);
                            m_phase = 2;
                        end
                        default: begin
                            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(NR'(1) << m_owner));
                            chk("rsp_rdata", 32'(bus.rsp_rdata_o), 32'(exp_q[0]));
                            chk("rsp_acc_en", 32'(bus.acc_en_o), 32'd0);
                            chk("rsp_bus", {16'd0, bus.addr_o, bus.wdata_o}, 32'd0);
                            chk("rsp_req_ready", 32'(bus.req_ready_o), 32'd0);
                            chk("rsp_busy", 32'(busy), 32'd1);
                            if (bus.rsp_ready_i[rid_t'(m_owner)]) begin
                                void'(exp_q.pop_front());
                                m_phase = 0;
                            end
                        end
                    endcase
                end
            end
        join_none

        // Reset values
        #1;
        chk("reset_acc_en", 32'(bus.acc_en_o), 32'd0);
        chk("reset_rsp_rdata", 32'(bus.rsp_rdata_o), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single write then read back from the other requester
        issue(0, 1'b1, 8'h02, 8'hA5);
        wait_idle();
        issue(1, 1'b0, 8'h02, 8'h00);
        wait_idle();

        // Contention from reset: both continuously valid for six grants
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        grant_log.delete();
        set_req(0, 1'b1, 8'h03, 8'h3C);
        set_req(1, 1'b0, 8'h03, 8'h00);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (grant_log.size() >= 6) break;
        end
        bus.req_valid_i = '0;
        chk("contention_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("grant_order", 32'(grant_log[i]), 32'(i % 2));
        end
        wait_idle();

        // Status register read-clear with the response held off for five cycles
        @(posedge clk);
        #1;
        inj_v = 8'h5A;
        @(posedge clk);
        #1;
        inj_v = 8'h00;
        bus.rsp_ready_i[0] = 1'b0;
        issue(0, 1'b0, STATUS_ADDR, 8'h00);
        wait_phase(2);
        repeat (5) @(posedge clk);
        #1;
        bus.rsp_ready_i[0] = 1'b1;
        wait_idle();
        issue(0, 1'b0, STATUS_ADDR, 8'h00);
        wait_idle();

        // Backpressure on requester 0 while requester 1 waits
        bus.rsp_ready_i[0] = 1'b0;
        issue(0, 1'b0, 8'h02, 8'h00);
        set_req(1, 1'b0, 8'h03, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        bus.rsp_ready_i[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready_o[1]) break;
        end
        @(posedge clk);
        #1;
        bus.req_valid_i[1] = 1'b0;
        wait_idle();

        // Same requester back-to-back, and out-of-range addresses
        issue(0, 1'b1, 8'h05, 8'h77);
        issue(0, 1'b0, 8'h05, 8'h00);
        wait_idle();
        issue(1, 1'b1, 8'h90, 8'h11);
        issue(1, 1'b0, 8'h90, 8'h00);
        wait_idle();

        // Reset asserted while the bank access is in progress
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 8'h02, 8'h00);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready_o[1]) break;
        end
        @(posedge clk);
        #1;
        chk("pre_reset_acc_en", 32'(bus.acc_en_o), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_acc_en", 32'(bus.acc_en_o), 32'd0);
        chk("async_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        bus.req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        grant_log.delete();
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 8'h02, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (grant_log.size() >= 1) break;
        end
        bus.req_valid_i = '0;
        chk("post_reset_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() >= 1) chk("post_reset_first", 32'(grant_log[0]), 32'd0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_access_arbiter.md
Name: regbank_access_arbiter

Overview:
- Shares the single access port of the filter register bank (acc_en/wr_en/addr/wdata/rdata) between NUM_REQ requesters, e.g. the host serial interface and the on-chip config sequencer.
- Round-robin arbitration; one bus access per transaction, held for exactly one clock, so a status-register read-clear fires once only.
- Each transaction returns a registered response (read data, or an ack for writes) to the owning requester over a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 8, address width; matches the register bank address width.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_wr_i  in  NUM_REQ  1 = write, 0 = read (read-clears status registers).
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*8  packed write data; requester k at [k*8 +: 8].
- rsp_valid_o  out  NUM_REQ  per-requester response valid (one-hot or zero).
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_rdata_o  out  8  response data, shared; meaningful only with rsp_valid_o.
- acc_en_o  out  1  bank access enable.
- wr_en_o  out  1  bank write enable.
- addr_o  out  ADDR_W  bank address.
- wdata_o  out  8  bank write data.
- rdata_i  in  8  bank read data (combinational from bank).
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; priority pointer = 0; latched request fields = 0.
- Reset is asynchronous. Assertion mid-transaction drops acc_en_o and rsp_valid_o immediately and discards the transaction; no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Winner = first requester with req_valid_i set, scanning ptr, ptr+1, ... mod NUM_REQ.
  - req_ready_o[winner] = 1 combinationally in the same cycle.
  - At the clock edge: latch winner id, wr, addr and wdata; set ptr = (winner+1) mod NUM_REQ; go to ACCESS.
  - No valid request: stay in IDLE with all outputs 0.
- ACCESS (exactly 1 cycle):
  - acc_en_o = 1; wr_en_o, addr_o and wdata_o come from the latched fields. All four are registered outputs.
  - At the edge: rsp_rdata_o <= rdata_i for a read, 0 for a write; go to RESP.
- RESP:
  - rsp_valid_o[owner] = 1; rsp_rdata_o is stable.
  - On rsp_ready_i[owner] = 1 at the edge, go to IDLE.
  - rsp_ready_i of non-owners is ignored.
- Bus outputs are 0 outside ACCESS, including addr_o and wdata_o. No X may reach the bank.
- req_ready_o is 0 in ACCESS and RESP; no pipelining.
- Latency:
  - Request accepted at cycle T; bus access at T+1; rsp_valid_o at T+2.
  - Minimum 3 cycles per transaction, or 4 if a new request is blocked by a response that completes the same cycle.
  - A new grant is possible only in the IDLE cycle after the response handshake.
- Requester rules:
  - Must hold valid, wr, addr and wdata until it sees ready.
  - May drop valid without penalty before it is granted.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 transactions.
- Out-of-range addresses are passed through unchanged; the bank returns 0 and the arbiter returns 0.
- Back-to-back requests from the same requester are allowed. If it is the only valid requester it is re-granted regardless of ptr.

Test Plan:
- Single write: req0 wr=1, addr=0x02, wdata=0xA5.
  -> req_ready_o[0] pulses 1 cycle; next cycle acc_en_o=1, wr_en_o=1, addr_o=0x02, wdata_o=0xA5 for exactly 1 cycle; then rsp_valid_o[0]=1 with rsp_rdata_o=0x00.
- Single read: req1 read addr=0x02 after the write above.
  -> acc_en_o=1, wr_en_o=0 for 1 cycle; rsp_valid_o[1]=1 with rsp_rdata_o=0xA5 at T+2.
- Contention: req0 and req1 valid every cycle for 6 transactions from reset.
  -> grant order 0,1,0,1,0,1; never two bits set in req_ready_o or rsp_valid_o.
- Status clear once: inject in_int into bank status at address N; read it with rsp_ready held 0 for 5 cycles.
  -> acc_en_o high 1 cycle only; returned value is the interrupt bits; a second read returns 0x00.
- Response backpressure: rsp_ready_i[0]=0 for 4 cycles while req1 is valid.
  -> rsp_valid_o[0] and rsp_rdata_o stay stable; req_ready_o[1]=0 until the cycle after the handshake.
- Reset mid-access: assert rstn_i low during ACCESS.
  -> acc_en_o, rsp_valid_o and busy_o go 0 asynchronously; after release, the first grant goes to req0 (ptr=0).
